// File: rtl/imem_loader_if.sv
// Byte-stream ingress and instruction-memory write port of the loader.
// The master side is the loader; the slave side is the byte source / memory.
interface imem_loader_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian bytes into 32-bit words, writes them to
// instruction memory, then releases the core from reset once the image is complete.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [15:0]          length,
    imem_loader_if.master        bus,
    output logic                 core_reset_n,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] len_q;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [31:0] word_buf;
    logic        err_q;

    logic can_start;
    logic len_ok;
    logic xfer;
    logic last_word;

    assign can_start = (state == IDLE) || (state == DONE);
    assign len_ok    = (length != 16'd0) && ({16'd0, length} <= MAX_WORDS);
    assign xfer      = (state == RECV) && bus.s_valid;
    assign last_word = ((word_idx + 16'd1) == len_q);

    // Address arithmetic wraps at 32 bits by construction.
    assign bus.mem_addr  = BASE_ADDR + {14'd0, word_idx, 2'b00};
    assign bus.mem_wdata = word_buf;
    assign err           = err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output and next_state gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        bus.s_ready      = 1'b0;
        bus.mem_we       = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        core_reset_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = len_ok ? RECV : IDLE;
            end
            RECV: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
                if (xfer && (byte_cnt == 2'd3)) state_next = WRITE;
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                busy       = 1'b1;
                state_next = last_word ? DONE : RECV;
            end
            DONE: begin
                done         = 1'b1;
                core_reset_n = 1'b1;
                if (start) state_next = len_ok ? RECV : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the word buffer is cleared on reset too, so a partial word from an
    // aborted load can never leak into a later write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_q    <= 16'd0;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            word_buf <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            if (can_start && start) begin
                if (len_ok) begin
                    len_q    <= length;
                    word_idx <= 16'd0;
                    byte_cnt <= 2'd0;
                    err_q    <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (xfer) begin
                word_buf[{byte_cnt, 3'b000} +: 8] <= bus.s_data;
                byte_cnt                          <= byte_cnt + 2'd1;
            end
            if ((state == WRITE) && !last_word) begin
                word_idx <= word_idx + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader: a byte-queue reference model
// predicts every memory write, load timing and handshake count.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          MAXW = 4096;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] length = 16'd0;
    logic        core_reset_n;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader_if bus_if ();

    imem_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .length       (length),
        .bus          (bus_if),
        .core_reset_n (core_reset_n),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    wr_t        exp_q[$];
    logic [7:0] stream_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_writes = 0;
    int         n_fired  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: word w is bytes 4w..4w+3 of the stream, little-endian,
    // written at BASE + 4w.
    task automatic plan_expected(input int len);
        wr_t e;
        exp_q.delete();
        for (int w = 0; w < len; w++) begin
            e.addr = BASE + 32'(4 * w);
            e.data = {stream_q[4*w+3], stream_q[4*w+2], stream_q[4*w+1], stream_q[4*w]};
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_random(input int len);
        stream_q.delete();
        for (int i = 0; i < 4 * len; i++) stream_q.push_back(8'($urandom_range(255)));
    endtask

    // Observes writes and handshakes; each 4th accepted byte must produce mem_we next cycle.
    task automatic monitor();
        int  mod4 = 0;
        bit  pend = 1'b0;
        wr_t e;
        forever begin
            @(negedge clk);
            if (pend) check("we_latency", {31'd0, bus_if.mem_we}, 32'd1);
            pend = 1'b0;
            if (bus_if.mem_we) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("write_expected", {31'd0, bus_if.mem_we}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus_if.mem_addr, e.addr);
                    check("wr_data", bus_if.mem_wdata, e.data);
                end
            end
            if (!reset_n) begin
                mod4 = 0;
            end else if (bus_if.s_valid && bus_if.s_ready) begin
                n_fired++;
                mod4 = (mod4 + 1) % 4;
                pend = (mod4 == 0);
            end
        end
    endtask

    // mode 0: valid every cycle, 1: valid toggles 1/0, 2: random valid.
    task automatic send_bytes(input int nbytes, input int mode);
        int sent  = 0;
        int guard = 0;
        bit phase = 1'b1;
        bit fire;
        while (sent < nbytes && guard < 4000) begin
            case (mode)
                0:       bus_if.s_valid = 1'b1;
                1:       bus_if.s_valid = phase;
                default: bus_if.s_valid = ($urandom_range(99) < 60);
            endcase
            phase = !phase;
            bus_if.s_data = stream_q[0];
            @(negedge clk);
            fire = bus_if.s_valid && bus_if.s_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                void'(stream_q.pop_front());
                sent++;
            end
            guard++;
        end
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = 8'($urandom_range(255));
        if (sent < nbytes) check("stream_sent", sent, nbytes);
    endtask

    task automatic do_start(input logic [15:0] len);
        start  = 1'b1;
        length = len;
        @(posedge clk);
        #1;
        start  = 1'b0;
        length = 16'($urandom_range(65535));
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (!done && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    // Runs a full load of the bytes already queued in stream_q.
    task automatic run_load(input int len, input int mode);
        int w0, f0, cyc;
        plan_expected(len);
        w0 = n_writes;
        f0 = n_fired;
        do_start(16'(len));
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_err", {31'd0, err}, 32'd0);
        check("start_core_rst", {31'd0, core_reset_n}, 32'd0);
        fork
            send_bytes(4 * len, mode);
            wait_done(20 * len + 40, cyc);
        join
        check("done_core_rst", {31'd0, core_reset_n}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_s_ready", {31'd0, bus_if.s_ready}, 32'd0);
        check("write_count", n_writes - w0, len);
        check("byte_count", n_fired - f0, 4 * len);
        check("writes_left", exp_q.size(), 0);
        if (mode == 0) check("load_cycles", cyc, 5 * len);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, {31'd0, bus_if.s_ready}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, bus_if.mem_we}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_core_rst"}, {31'd0, core_reset_n}, 32'd0);
    endtask

    task automatic check_rejected(input string tag);
        check({tag, "_err"}, {31'd0, err}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_core_rst"}, {31'd0, core_reset_n}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, f0, cyc;
        logic [15:0] bad;
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = 8'd0;
        fork
            monitor();
        join_none

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("in_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("after_reset");

        // Two words, continuous stream
        stream_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        run_load(2, 0);

        // One word with valid toggling; restart from DONE
        stream_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(1, 1);

        // Illegal lengths are rejected and err is sticky until a good start
        w0 = n_writes;
        do_start(16'd0);
        check_rejected("len0");
        do_start(16'd4097);
        check_rejected("len4097");
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", {31'd0, err}, 32'd1);
        check("rejected_writes", n_writes - w0, 0);
        fill_random(1);
        run_load(1, 2);

        // start while busy is ignored
        fill_random(3);
        plan_expected(3);
        w0 = n_writes;
        do_start(16'd3);
        send_bytes(2, 0);
        do_start(16'd9);
        check("busy_start_busy", {31'd0, busy}, 32'd1);
        check("busy_start_core_rst", {31'd0, core_reset_n}, 32'd0);
        check("busy_start_err", {31'd0, err}, 32'd0);
        fork
            send_bytes(10, 2);
            wait_done(300, cyc);
        join
        check("busy_start_writes", n_writes - w0, 3);
        check("busy_start_left", exp_q.size(), 0);

        // Reset mid-word drops the partial word
        fill_random(2);
        plan_expected(2);
        w0 = n_writes;
        f0 = n_fired;
        do_start(16'd2);
        send_bytes(3, 0);
        check("pre_abort_bytes", n_fired - f0, 3);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_writes", n_writes - w0, 0);
        exp_q.delete();
        stream_q.delete();

        // From IDLE, then restart from DONE
        fill_random(1);
        run_load(1, 0);
        fill_random(1);
        run_load(1, 0);

        // Randomised loads mixed with rejected starts
        repeat (10) begin
            if ($urandom_range(3) == 0) begin
                bad = ($urandom_range(1) == 0) ? 16'd0 : 16'($urandom_range(65535, MAXW + 1));
                w0  = n_writes;
                do_start(bad);
                check_rejected("rand_bad");
                check("rand_bad_writes", n_writes - w0, 0);
            end else begin
                int len;
                len = $urandom_range(5, 1);
                fill_random(len);
                run_load(len, int'($urandom_range(2)));
            end
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
